// File: rtl/sprite_sram_arbiter_if.sv
// Bus bundle between the sprite fetch requesters, the image loader,
// the sprite SRAM and the arbiter.
//
// Signals:
//   rd_req/rd_addr        per-requester read request and packed addresses
//   rd_gnt                one-hot read grant (combinational)
//   rd_valid/rd_id/rd_data read return, one cycle after the grant
//   wr_req/wr_addr/wr_data loader write request
//   wr_gnt                write accepted this cycle
//   sram_en/sram_we/sram_addr/sram_wdata  SRAM control toward the RAM
//   sram_rdata            registered read data from the RAM
//
// Modports:
//   master  requesters + loader + SRAM side (drives requests and sram_rdata)
//   slave   the arbiter
interface sprite_sram_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2
);
  logic [NUM_REQ-1:0]            rd_req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_REQ-1:0]            rd_gnt;
  logic                          rd_valid;
  logic [ID_WIDTH-1:0]           rd_id;
  logic [DATA_WIDTH-1:0]         rd_data;
  logic                          wr_req;
  logic [ADDR_WIDTH-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic                          wr_gnt;
  logic                          sram_en;
  logic                          sram_we;
  logic [ADDR_WIDTH-1:0]         sram_addr;
  logic [DATA_WIDTH-1:0]         sram_wdata;
  logic [DATA_WIDTH-1:0]         sram_rdata;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, sram_rdata,
    input  rd_gnt, rd_valid, rd_id, rd_data, wr_gnt,
           sram_en, sram_we, sram_addr, sram_wdata
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, sram_rdata,
    output rd_gnt, rd_valid, rd_id, rd_data, wr_gnt,
           sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sprite_sram_arbiter.sv
// Single-port sprite SRAM arbiter.
// Shares one registered-read SRAM between NUM_REQ pixel-fetch readers
// (round-robin) and one image-loader write port (absolute priority).
// At most one access is granted per clock. Read data comes back tagged
// with the requester index one cycle after the grant.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    sprite_sram_arbiter_if.slave (requests, grants, read return,
//          SRAM control and read data)
module sprite_sram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  sprite_sram_arbiter_if.slave  bus
);

  // Unpacked view of the per-requester addresses.
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_addr
      assign addr_arr[gi] = bus.rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  logic [ID_WIDTH-1:0]   rr_ptr_reg;
  logic [ID_WIDTH-1:0]   rr_ptr_next;
  logic                  rd_valid_reg;
  logic [ID_WIDTH-1:0]   rd_id_reg;

  logic [NUM_REQ-1:0]    rd_gnt_next;
  logic                  wr_gnt_next;
  logic                  sram_en_next;
  logic                  sram_we_next;
  logic [ADDR_WIDTH-1:0] sram_addr_next;
  logic [DATA_WIDTH-1:0] sram_wdata_next;
  logic [ID_WIDTH-1:0]   gnt_idx;
  logic                  rd_fire;
  logic                  rd_valid_out;

  // (base + offset) mod NUM_REQ; offset is always < NUM_REQ, so a single
  // conditional subtract is enough and works for non-power-of-two counts.
  function automatic logic [ID_WIDTH-1:0] wrap_idx(input logic [ID_WIDTH-1:0] base,
                                                   input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return sum[ID_WIDTH-1:0];
  endfunction

  // Arbitration: write first, then the first reader at or after rr_ptr.
  always_comb begin
    rd_gnt_next     = '0;
    wr_gnt_next     = 1'b0;
    sram_en_next    = 1'b0;
    sram_we_next    = 1'b0;
    sram_addr_next  = '0;
    sram_wdata_next = '0;
    gnt_idx         = '0;
    rd_fire         = 1'b0;
    if (!reset) begin
      if (bus.wr_req) begin
        wr_gnt_next     = 1'b1;
        sram_en_next    = 1'b1;
        sram_we_next    = 1'b1;
        sram_addr_next  = bus.wr_addr;
        sram_wdata_next = bus.wr_data;
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!rd_fire && bus.rd_req[wrap_idx(rr_ptr_reg, k)]) begin
            rd_fire = 1'b1;
            gnt_idx = wrap_idx(rr_ptr_reg, k);
          end
        end
        if (rd_fire) begin
          rd_gnt_next[gnt_idx] = 1'b1;
          sram_en_next         = 1'b1;
          sram_addr_next       = addr_arr[gnt_idx];
        end
      end
    end
  end

  // Pointer moves just past the granted reader; writes and idle leave it.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (rd_fire) begin
      if (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) rr_ptr_next = '0;
      else                                   rr_ptr_next = gnt_idx + ID_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg   <= '0;
      rd_valid_reg <= 1'b0;
      rd_id_reg    <= '0;
    end else begin
      rr_ptr_reg   <= rr_ptr_next;
      rd_valid_reg <= rd_fire;
      if (rd_fire) rd_id_reg <= gnt_idx;
    end
  end

  // A read granted just before reset is asserted is dropped: the return
  // is masked for the whole reset cycle, not only after the reset edge.
  assign rd_valid_out   = rd_valid_reg & ~reset;

  assign bus.rd_gnt     = rd_gnt_next;
  assign bus.wr_gnt     = wr_gnt_next;
  assign bus.sram_en    = sram_en_next;
  assign bus.sram_we    = sram_we_next;
  assign bus.sram_addr  = sram_addr_next;
  assign bus.sram_wdata = sram_wdata_next;
  assign bus.rd_valid   = rd_valid_out;
  assign bus.rd_id      = rd_id_reg;
  assign bus.rd_data    = rd_valid_out ? bus.sram_rdata : '0;

endmodule
